comparator_32bit_unsigned_gteq_serial: RTL

COMPARATOR_32BIT_UNSIGNED_GTEQ_SERIAL -- requirements
Module: comparator_32bit_unsigned_gteq_serial

---
 rtl/comparator_32bit_unsigned_gteq_serial_pkg.sv | 16 +
 rtl/comparator_32bit_unsigned_gteq_serial_nibble_cmp.sv | 17 +
 rtl/comparator_32bit_unsigned_gteq_serial.sv | 121 ++++++++++++
 3 files changed

// File: rtl/comparator_32bit_unsigned_gteq_serial_pkg.sv
// Shared constants and state encoding for the serial nibble-wise unsigned comparator.
package comparator_32bit_unsigned_gteq_serial_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = WIDTH / NIB_W;
  // Wide enough to hold NUM_NIB (counts 0..8)
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/comparator_32bit_unsigned_gteq_serial_nibble_cmp.sv
// Combinational unsigned compare of one NIB_W-bit slice.
// Ports: a_i, b_i - nibbles to compare; gt - a_i > b_i; eq - a_i == b_i.
module nibble_cmp
  import comparator_32bit_unsigned_gteq_serial_pkg::*;
#(
  parameter int unsigned NIB_W = comparator_32bit_unsigned_gteq_serial_pkg::NIB_W
) (
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  output logic             gt,
  output logic             eq
);

  assign gt = (a_i > b_i);
  assign eq = (a_i == b_i);

endmodule

// File: rtl/comparator_32bit_unsigned_gteq_serial.sv
// Serial unsigned A >= B / A == B comparator, one nibble per cycle, MSB first.
// Ports: clk/rst - clock, sync active-high reset;
//        in_valid/in_ready/a/b - operand handshake;
//        out_valid/out_ready/gteq/eq/nib_cnt - result handshake and payload.
module comparator_32bit_unsigned_gteq_serial
  import comparator_32bit_unsigned_gteq_serial_pkg::*;
#(
  parameter int unsigned WIDTH = comparator_32bit_unsigned_gteq_serial_pkg::WIDTH,
  parameter int unsigned NIB_W = comparator_32bit_unsigned_gteq_serial_pkg::NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gteq,
  output logic             eq,
  output logic [CNT_W-1:0] nib_cnt
);

  localparam int unsigned NNIB = WIDTH / NIB_W;

  if ((WIDTH % NIB_W) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of NIB_W");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gteq_q;
  logic             eq_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             nib_gt;
  logic             nib_eq;
  logic             in_xfer;

  assign in_xfer = in_valid && in_ready_q;

  // Current top nibble of the shifting operand registers
  nibble_cmp #(.NIB_W(NIB_W)) u_nibble_cmp (
    .a_i (a_q[WIDTH-1 -: NIB_W]),
    .b_i (b_q[WIDTH-1 -: NIB_W]),
    .gt  (nib_gt),
    .eq  (nib_eq)
  );

  // Operand registers: loaded on transfer, shifted left one nibble per equal SCAN step
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_xfer) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == SCAN) begin
      a_q <= a_q << NIB_W;
      b_q <= b_q << NIB_W;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gteq_q      <= 1'b0;
      eq_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            gteq_q     <= 1'b0;
            eq_q       <= 1'b0;
            in_ready_q <= 1'b0;
          end
        end
        SCAN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!nib_eq) begin
            gteq_q      <= nib_gt;
            eq_q        <= 1'b0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else if (cnt_q == CNT_W'(NNIB - 1)) begin
            // Every nibble matched
            gteq_q      <= 1'b1;
            eq_q        <= 1'b1;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign gteq      = gteq_q;
  assign eq        = eq_q;
  assign nib_cnt   = cnt_q;

endmodule
